gf277_modexp: RTL and testbench



---
 rtl/gf277_modexp.sv | 115 +++++++++++
 tb/tb_gf277_modexp.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/gf277_modexp.sv
// Left-to-right square-and-multiply exponentiator over GF(277).
// Products go out on red_din; the external Barrett reducer returns red_dout in the same cycle.
module gf277_modexp #(
    parameter int P     = 277,
    parameter int EXP_W = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [8:0]       base,
    input  logic [EXP_W-1:0] exp,
    output logic             busy,
    output logic             done,
    output logic [8:0]       result,
    output logic [16:0]      red_din,
    input  logic [8:0]       red_dout
);

    localparam int RW    = $clog2(P);
    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQR,
        MUL,
        DONE
    } state_t;

    state_t            state, state_next;
    logic [RW-1:0]     acc;
    logic [8:0]        b;
    logic [EXP_W-1:0]  exp_r;
    logic [IDX_W-1:0]  idx;
    logic              last_bit;

    assign last_bit = (idx == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        red_din    = '0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = LOAD;
            end
            LOAD: begin
                red_din    = 17'(b);
                state_next = SQR;
            end
            SQR: begin
                red_din = 17'(acc) * 17'(acc);
                if (exp_r[idx])    state_next = MUL;
                else if (last_bit) state_next = DONE;
            end
            MUL: begin
                red_din    = 17'(acc) * 17'(b);
                state_next = last_bit ? DONE : SQR;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // b holds the raw base until LOAD, then its reduced residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            b      <= '0;
            exp_r  <= '0;
            idx    <= '0;
            result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= RW'(1);
                        b     <= base;
                        exp_r <= exp;
                    end
                end
                LOAD: begin
                    b   <= red_dout;
                    idx <= IDX_W'(EXP_W - 1);
                end
                SQR: begin
                    acc <= RW'(red_dout);
                    if (!exp_r[idx] && !last_bit) idx <= idx - 1'b1;
                end
                MUL: begin
                    acc <= RW'(red_dout);
                    if (!last_bit) idx <= idx - 1'b1;
                end
                default: ;
            endcase
            if ((state == SQR || state == MUL) && state_next == DONE) begin
                result <= red_dout;
            end
        end
    end

endmodule

// File: tb/tb_gf277_modexp.sv
// Bench for gf277_modexp: models the external mod-277 reducer and checks result and done latency.
module tb_gf277_modexp;

    localparam int EXP_W = 9;
    localparam int MOD   = 277;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [8:0]       base;
    logic [EXP_W-1:0] exp;
    logic             busy;
    logic             done;
    logic [8:0]       result;
    logic [16:0]      red_din;
    logic [8:0]       red_dout;

    gf277_modexp #(.P(277), .EXP_W(EXP_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base),
        .exp      (exp),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .red_din  (red_din),
        .red_dout (red_dout)
    );

    // Stand-in for the combinational Barrett reducer.
    assign red_dout = 9'(red_din % 17'd277);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int res;
        int lat;
        int acc_cyc;
    } sb_t;

    typedef struct {
        int base;
        int exp;
        int res;
        int lat;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic int ref_pow(input int bse, input int e);
        int r;
        r = 1;
        for (int i = 0; i < e; i++) r = (r * (bse % MOD)) % MOD;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Launch one operation, optionally poking start mid-flight and in the DONE cycle.
    task automatic run_op(input int bse, input int e, input int req_res, input int req_lat,
                          input bit poke_mid, input bit poke_done);
        sb_t s;
        bit  seen;
        @(negedge clk);
        check("idle_before_start", int'(busy), 0);
        base  = 9'(bse);
        exp   = EXP_W'(e);
        start = 1'b1;
        s.res = req_res;
        s.lat = req_lat;
        s.acc_cyc = cyc + 1;
        sb_q.push_back(s);
        @(negedge clk);
        start = 1'b0;
        base  = 9'($urandom);
        exp   = EXP_W'($urandom);
        seen  = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy) check("busy_in_flight", int'(busy), 1);
            start = (poke_mid && (k == 4)) ? 1'b1 : 1'b0;
            @(negedge clk);
        end
        s = sb_q.pop_front();
        if (!seen) begin
            check("done_timeout", 0, 1);
        end else begin
            check("busy_at_done", int'(busy), 1);
            check("result", int'(result), s.res);
            check("latency", cyc - s.acc_cyc, s.lat);
            if (poke_done) begin
                base  = 9'd7;
                exp   = EXP_W'(3);
                start = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            check("done_single_pulse", int'(done), 0);
            check("busy_after_done", int'(busy), 0);
            check("result_held", int'(result), s.res);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        base  = '0;
        exp   = '0;

        vecs.push_back('{3,   5,   243, 12});
        vecs.push_back('{2,   276, 1,   13});
        vecs.push_back('{300, 1,   23,  11});
        vecs.push_back('{276, 2,   1,   11});
        vecs.push_back('{0,   0,   1,   10});
        vecs.push_back('{0,   7,   0,   13});
        vecs.push_back('{5,   511, ref_pow(5, 511), 19});

        #12;
        check("rst_busy",    int'(busy),    0);
        check("rst_done",    int'(done),    0);
        check("rst_result",  int'(result),  0);
        check("rst_red_din", int'(red_din), 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].base, vecs[i].exp, vecs[i].res, vecs[i].lat, 1'b0, 1'b0);

        // Start pulses mid-flight and during DONE must be ignored; next start then accepted.
        run_op(3, 5, 243, 12, 1'b1, 1'b1);
        @(negedge clk);
        check("poke_not_accepted", int'(busy), 0);
        run_op(2, 276, 1, 13, 1'b0, 1'b0);
        run_op(300, 1, 23, 11, 1'b0, 1'b0);

        // Asynchronous reset while in MUL (3^5: first MUL is 9 cycles after accept, acc*b = 1*3).
        @(negedge clk);
        base  = 9'd3;
        exp   = EXP_W'(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("mul_red_din", int'(red_din), 3);
        check("mul_busy", int'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy",    int'(busy),    0);
        check("arst_done",    int'(done),    0);
        check("arst_result",  int'(result),  0);
        check("arst_red_din", int'(red_din), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(3, 5, 243, 12, 1'b0, 1'b0);

        for (int n = 0; n < 2000; n++) begin
            int rb, re;
            rb = int'($urandom_range(0, 511));
            re = int'($urandom_range(0, 511));
            run_op(rb, re, ref_pow(rb, re), EXP_W + $countones(9'(re)) + 1, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
